// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types and constants for the seven-segment scan controller.
//   state_t   - scan controller state (IDLE, SCAN)
//   SEG_LUT   - hex digit -> active-low {g,f,e,d,c,b,a} pattern
//   SEG_BLANK - all segments off
package sseg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Indexed by nibble value 0..F
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_sseg.sv
// hex_to_sseg: combinational hex-nibble to seven-segment decoder.
//   nib - 4-bit hex value
//   seg - active-low segments {g,f,e,d,c,b,a}
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed scan of DIGITS common-anode digits sharing
// one cathode bus. The displayed value is captured once per frame so a frame
// never mixes old and new digits.
//   CLK        - system clock, all state on rising edge
//   RST        - synchronous active-high reset (overrides EN)
//   EN         - scan enable; low blanks the display
//   DATA       - hex nibbles, nibble i on digit i (digit 0 rightmost)
//   AN         - active-low anode enables, at most one low
//   SEG        - active-low segments {g,f,e,d,c,b,a}
//   FRAME_DONE - one-cycle pulse as the last digit's slot ends
// Build option: define SSEG_LEADING_ZERO_BLANK_EN to blank digits above the
// most significant nonzero nibble (digit 0 always shows).
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_DIGIT = 100000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [4*DIGITS-1:0]   DATA,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            SEG,
    output logic                  FRAME_DONE
);

    localparam int CNT_W = $clog2(TICKS_PER_DIGIT + 1);
    // Keep idx at least one bit wide so DIGITS=1 still elaborates
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       cnt;
    logic [DIGITS-1:0][3:0] snapshot;
    logic [6:0]             seg_dec;
    logic [DIGITS-1:0]      an_sel;
    logic                   digit_on;

    assign an_sel = ~(DIGITS'(1) << idx);

    hex_to_sseg u_dec (
        .nib (snapshot[idx]),
        .seg (seg_dec)
    );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // Highest nonzero nibble; stays 0 for an all-zero value so "0" shows
    logic [IDX_W-1:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++)
            if (snapshot[i] != 4'h0) msd = IDX_W'(i);
    end
    assign digit_on = (idx <= msd);
`else
    assign digit_on = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            snapshot   <= '0;
            AN         <= '1;
            SEG        <= SEG_BLANK;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    AN  <= '1;
                    SEG <= SEG_BLANK;
                    if (EN) begin
                        snapshot <= DATA;
                        idx      <= '0;
                        cnt      <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (!EN) begin
                        // Disable beats a coincident frame wrap: no pulse, no reload
                        state <= IDLE;
                        idx   <= '0;
                        cnt   <= '0;
                        AN    <= '1;
                        SEG   <= SEG_BLANK;
                    end else begin
                        // Outputs follow the current idx, so they lag it by one cycle
                        AN  <= digit_on ? an_sel  : '1;
                        SEG <= digit_on ? seg_dec : SEG_BLANK;
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (idx == IDX_LAST) begin
                                idx        <= '0;
                                snapshot   <= DATA;
                                FRAME_DONE <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int TPD    = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [15:0] DATA;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        FRAME_DONE;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests  = 0;
    int   failed = 0;

    logic [6:0] lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    sseg_scan_ctrl #(.DIGITS(DIGITS), .TICKS_PER_DIGIT(TPD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .DATA       (DATA),
        .AN         (AN),
        .SEG        (SEG),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic push_blank(input int n);
        for (int k = 0; k < n; k++) q.push_back('{4'b1111, 7'b1111111, 1'b0});
    endtask

    // Expected entries for digits [first..last] of a frame showing d
    task automatic push_digits(input logic [15:0] d, input int first, input int last);
        int  msd;
        bit  blank;
        logic [3:0] nb;
        msd = 0;
        for (int k = 1; k < DIGITS; k++) if (d[4*k +: 4] != 4'h0) msd = k;
        for (int dg = first; dg <= last; dg++) begin
            nb    = d[4*dg +: 4];
            blank = LZB && (dg > msd);
            for (int t = 0; t < TPD; t++)
                q.push_back('{blank ? 4'b1111 : ~(4'b0001 << dg),
                              blank ? 7'b1111111 : lut[nb],
                              (dg == DIGITS-1) && (t == TPD-1)});
        end
    endtask

    // Hold reset one cycle, then release with EN=1 and DATA=d
    task automatic restart(input logic [15:0] d);
        @(negedge CLK);
        RST = 1'b1; EN = 1'b1; DATA = d;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1; EN = 1'b1; DATA = 16'h1234;
        push_blank(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            e = q.pop_front();
            tests++;
            if (AN !== e.an || SEG !== e.seg || FRAME_DONE !== e.fd) begin
                failed++;
                $display("FAIL reset[%0d]: got AN=%b SEG=%b FD=%b want AN=%b SEG=%b FD=%b",
                         i, AN, SEG, FRAME_DONE, e.an, e.seg, e.fd);
            end
        end
    endtask

    task automatic test_scan;
        int n;
        restart(16'h1234);
        push_blank(1);
        push_digits(16'h1234, 0, 3);
        push_digits(16'h1234, 0, 3);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            e = q.pop_front();
            tests++;
            if (AN !== e.an || SEG !== e.seg || FRAME_DONE !== e.fd) begin
                failed++;
                $display("FAIL scan[%0d]: got AN=%b SEG=%b FD=%b want AN=%b SEG=%b FD=%b",
                         i, AN, SEG, FRAME_DONE, e.an, e.seg, e.fd);
            end
        end
    endtask

    task automatic test_snapshot;
        int n;
        restart(16'h1234);
        push_blank(1);
        push_digits(16'h1234, 0, 3);
        push_digits(16'hABCD, 0, 3);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            e = q.pop_front();
            tests++;
            if (AN !== e.an || SEG !== e.seg || FRAME_DONE !== e.fd) begin
                failed++;
                $display("FAIL snapshot[%0d]: got AN=%b SEG=%b FD=%b want AN=%b SEG=%b FD=%b",
                         i, AN, SEG, FRAME_DONE, e.an, e.seg, e.fd);
            end
            if (i == 5) DATA = 16'hABCD;  // digit 1 is lit
        end
    endtask

    task automatic test_enable_drop;
        int n;
        restart(16'h1234);
        push_blank(1);
        push_digits(16'h1234, 0, 1);
        q.push_back('{4'b1011, lut[2], 1'b0});
        push_blank(3);
        push_digits(16'h5678, 0, 3);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            e = q.pop_front();
            tests++;
            if (AN !== e.an || SEG !== e.seg || FRAME_DONE !== e.fd) begin
                failed++;
                $display("FAIL en_drop[%0d]: got AN=%b SEG=%b FD=%b want AN=%b SEG=%b FD=%b",
                         i, AN, SEG, FRAME_DONE, e.an, e.seg, e.fd);
            end
            if (i == 9) begin EN = 1'b0; DATA = 16'h5678; end
            if (i == 11) EN = 1'b1;
        end
    endtask

    task automatic test_reset_mid;
        int n;
        restart(16'h1234);
        push_blank(1);
        push_digits(16'h1234, 0, 2);
        q.push_back('{4'b0111, lut[1], 1'b0});
        push_blank(3);
        push_digits(16'h1234, 0, 3);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            e = q.pop_front();
            tests++;
            if (AN !== e.an || SEG !== e.seg || FRAME_DONE !== e.fd) begin
                failed++;
                $display("FAIL reset_mid[%0d]: got AN=%b SEG=%b FD=%b want AN=%b SEG=%b FD=%b",
                         i, AN, SEG, FRAME_DONE, e.an, e.seg, e.fd);
            end
            if (i == 13) RST = 1'b1;
            if (i == 15) RST = 1'b0;
        end
    endtask

    task automatic test_leading_zero;
        int n;
        restart(16'h0050);
        push_blank(1);
        push_digits(16'h0050, 0, 3);
        push_digits(16'h0000, 0, 3);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            e = q.pop_front();
            tests++;
            if (AN !== e.an || SEG !== e.seg || FRAME_DONE !== e.fd) begin
                failed++;
                $display("FAIL lead_zero[%0d]: got AN=%b SEG=%b FD=%b want AN=%b SEG=%b FD=%b",
                         i, AN, SEG, FRAME_DONE, e.an, e.seg, e.fd);
            end
            if (i == 3) DATA = 16'h0000;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_enable_drop();
        test_reset_mid();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexes one shared seven-segment cathode bus across DIGITS common-anode digits.
- Holds a tear-free snapshot of the display value for one whole frame.
- Drives active-low anode enables and decoded segments, and pulses once per completed frame.
- Sits between the lab datapath (value to show) and the board's display pins.

Parameters:
- DIGITS, 4, number of digits scanned; 1..8.
- TICKS_PER_DIGIT, 100000, CLK cycles each digit stays lit; must be >= 1; 100000 gives 1 kHz per digit at 100 MHz.
- CNT_W, $clog2(TICKS_PER_DIGIT+1), localparam, prescaler width.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  scan enable; 0 blanks the display.
- DATA  input  4*DIGITS  hex nibbles; nibble i shown on digit i; digit 0 is rightmost.
- AN  output  DIGITS  anode enables, active-low, at most one bit low.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- FRAME_DONE  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - Clock port is CLK and reset port is RST.
- Reset values: state IDLE, idx=0, cnt=0, snapshot=0, AN=all 1s, SEG=7'b1111111, FRAME_DONE=0. RST overrides EN.
- States:
  - IDLE:
    - AN all 1s and SEG all 1s (registered).
    - When EN=1: snapshot<=DATA, idx<=0, cnt<=0, go to SCAN.
  - SCAN:
    - If EN=0: go to IDLE and blank on the next cycle; idx and cnt return to 0.
    - Else cnt increments each cycle.
    - When cnt==TICKS_PER_DIGIT-1: cnt<=0 and idx advances.
    - Wrap: when idx==DIGITS-1, idx<=0, snapshot<=DATA, FRAME_DONE<=1 for exactly one cycle.
- Outputs are registered:
  - AN = ~(1<<idx) and SEG = decode(snapshot[4*idx+:4]).
  - Both take effect one cycle after idx or state changes.
  - First lit cycle is 2 cycles after EN rises in IDLE.
- Snapshot rule: DATA changes mid-frame do not affect the display until the next frame boundary.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- TICKS_PER_DIGIT=1: idx advances every SCAN cycle; FRAME_DONE pulses every DIGITS cycles.
- DIGITS=1: AN constant 0 in SCAN; FRAME_DONE pulses every TICKS_PER_DIGIT cycles.
- Simultaneous EN fall and frame wrap: IDLE wins, FRAME_DONE=0, snapshot not reloaded.

Optional Feature:
- SSEG_LEADING_ZERO_BLANK_EN, defined:
  - Digits above the most significant nonzero snapshot nibble keep their AN bit high during their slot.
  - Their SEG is all 1s.
  - Digit 0 always shows, so value 0 displays "0".
  - Slot timing and FRAME_DONE are unchanged.
- Undefined: every digit shows every frame.

Decomposition:
- Shared package sseg_pkg:
  - state_t enum {IDLE, SCAN}.
  - 16-entry SEG_LUT constant (active-low patterns above).
  - SEG_BLANK = 7'b1111111.
- Sub-module hex_to_sseg: purely combinational, 4-bit nibble in, 7-bit SEG out, using SEG_LUT.
- Controller instantiates one hex_to_sseg fed by the selected snapshot nibble.

Test Plan (DIGITS=4, TICKS_PER_DIGIT=4):
- Reset: RST=1 with EN=1 for 3 cycles -> AN=1111, SEG=1111111, FRAME_DONE=0 throughout.
- Scan order:
  - DATA=16'h1234, EN=1 -> AN 1110/1101/1011/0111, each held 4 cycles.
  - SEG per slot 0011001, 0110000, 0100100, 1111001.
  - FRAME_DONE one pulse per 16 cycles.
- Snapshot: after 16'h1234 is loaded, set DATA=16'hABCD during digit 1 -> digits 1..3 still show 3,2,1; after FRAME_DONE the frame shows 0100001, 1000110, 0000011, 0001000.
- Enable drop: EN=0 during digit 2 -> next cycle AN=1111; EN=1 again -> digit 0 lit 2 cycles later with the fresh snapshot.
- Reset mid-scan: RST=1 during digit 3 -> next cycle all outputs at reset values; scan restarts at digit 0 after RST falls.
- Leading-zero blank: DATA=16'h0050.
  - With SSEG_LEADING_ZERO_BLANK_EN: AN never equals 1011 or 0111.
  - Without it: all four anodes assert and digits 2,3 show 1000000.
